// File: rtl/kb_pkg.sv
// Shared types and helpers for the 8x5 key-matrix scanner.
package kb_pkg;

  localparam int KB_ROWS = 8;
  localparam int KB_COLS = 5;
  localparam int KB_KEYS = 40;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EVAL} kb_scan_state_e;

  typedef struct packed {
    logic       press;
    logic [5:0] code;
  } kb_evt_t;

  // Rows 0..3 map to A11..A8 and rows 4..7 to A15..A12; A7..A0 are never driven low.
  function automatic logic [15:0] row_to_ain(input logic [2:0] row);
    logic [15:0] ain;
    ain = 16'hFFFF;
    case (row)
      3'd0: ain[11] = 1'b0;
      3'd1: ain[10] = 1'b0;
      3'd2: ain[9]  = 1'b0;
      3'd3: ain[8]  = 1'b0;
      3'd4: ain[15] = 1'b0;
      3'd5: ain[14] = 1'b0;
      3'd6: ain[13] = 1'b0;
      default: ain[12] = 1'b0;
    endcase
    return ain;
  endfunction

endpackage

// File: rtl/kb_evt_fifo.sv
// Synchronous event queue; the writer must only push when !full or when popping in the same cycle.
module kb_evt_fifo
  import kb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  kb_evt_t push_data,
  output logic    full,
  input  logic    pop,
  output logic    empty,
  output kb_evt_t head
);

  localparam int AW = $clog2(DEPTH);

  kb_evt_t       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/kb_scan_ctrl.sv
// Autonomous 8x5 key-matrix scanner with per-key debounce and a press/release event queue.
module kb_scan_ctrl
  import kb_pkg::*;
#(
  parameter int SETTLE_CYC     = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [15:0]        scan_ain,
  input  logic [7:0]         kb_din,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [5:0]         ev_code,
  output logic               ev_press,
  output logic [KB_KEYS-1:0] key_state,
  output logic               scan_done,
  output kb_scan_state_e     dbg_state
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_SCANS - 1);

  kb_scan_state_e state_q, state_d;
  logic [2:0]     row_q, row_d;
  logic [2:0]     col_q, col_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic           done_d;
  logic [4:0]     cols_q;
  logic [CW-1:0]  cnt_q [KB_KEYS];

  logic [5:0]     key_idx;
  logic [CW-1:0]  cnt_cur;
  logic           raw, cur, in_eval, flip, bump, stall;
  logic           pop, push, can_push, fifo_full, fifo_empty;
  kb_evt_t        push_evt, head_evt;
  logic [2:0]     unused_din;

  assign unused_din = kb_din[7:5];

  // Event handshake: an event transfers on any cycle where ev_valid && ev_ready;
  // ev_valid stays high and ev_code/ev_press stay stable until that transfer.
  assign ev_valid = !fifo_empty;
  assign ev_code  = head_evt.code;
  assign ev_press = head_evt.press;
  assign pop      = ev_valid && ev_ready;
  assign can_push = !fifo_full || pop;
  assign dbg_state = state_q;

  assign key_idx  = ({3'b000, row_q} * 6'd5) + {3'b000, col_q};
  assign cnt_cur  = cnt_q[key_idx];
  assign raw      = cols_q[col_q];
  assign cur      = key_state[key_idx];
  assign in_eval  = (state_q == EVAL);
  assign flip     = in_eval && (raw != cur) && (cnt_cur == CNT_LAST);
  assign bump     = in_eval && (raw != cur) && (cnt_cur != CNT_LAST);
  assign stall    = flip && !can_push;
  assign push     = flip && can_push;
  assign push_evt = {raw, key_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      settle_q  <= '0;
      scan_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      scan_done <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    done_d   = 1'b0;
    scan_ain = (state_q == IDLE) ? 16'hFFFF : row_to_ain(row_q);
    case (state_q)
      IDLE: begin
        row_d = '0;
        if (en) begin
          state_d  = DRIVE;
          settle_d = '0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else                         settle_d = settle_q + 1'b1;
      end
      SAMPLE: begin
        state_d = EVAL;
        col_d   = '0;
      end
      EVAL: begin
        // A stalled column holds everything until the queue can take its event.
        if (!stall) begin
          if (col_q == 3'd4) begin
            col_d    = '0;
            settle_d = '0;
            if (row_q == 3'd7) begin
              done_d = 1'b1;
              row_d  = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
            if (en) begin
              state_d = DRIVE;
            end else begin
              state_d = IDLE;
              row_d   = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_q    <= '0;
      key_state <= '0;
      for (int i = 0; i < KB_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      if (state_q == SAMPLE) cols_q <= ~kb_din[4:0];
      if (push) begin
        key_state[key_idx] <= raw;
        cnt_q[key_idx]     <= '0;
      end else if (bump) begin
        cnt_q[key_idx] <= cnt_cur + 1'b1;
      end else if (in_eval && (raw == cur)) begin
        cnt_q[key_idx] <= '0;
      end
    end
  end

  kb_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .full      (fifo_full),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (head_evt)
  );

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl: a key-matrix model drives kb_din, expectations are hand-timed.
module tb_kb_scan_ctrl;
  import kb_pkg::*;

  localparam int ROW_BIT [8] = '{11, 10, 9, 8, 15, 14, 13, 12};
  localparam logic [15:0] ROW_AIN [8] = '{16'hF7FF, 16'hFBFF, 16'hFDFF, 16'hFEFF,
                                          16'h7FFF, 16'hBFFF, 16'hDFFF, 16'hEFFF};

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [15:0]        scan_ain;
  logic [7:0]         kb_din;
  logic               ev_valid;
  logic               ev_ready;
  logic [5:0]         ev_code;
  logic               ev_press;
  logic [KB_KEYS-1:0] key_state;
  logic               scan_done;
  kb_scan_state_e     dbg_state;

  logic [KB_KEYS-1:0] keys;
  logic [4:0]         mx_pressed;
  int                 cyc;
  int                 n_chk;
  int                 n_pass;

  kb_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .scan_ain  (scan_ain),
    .kb_din    (kb_din),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_press  (ev_press),
    .key_state (key_state),
    .scan_done (scan_done),
    .dbg_state (dbg_state)
  );

  // clock / reset-relative cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // matrix model: a column reads 0 when any pressed key in it sits on a selected row
  always_comb begin
    mx_pressed = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c] && !scan_ain[ROW_BIT[r]]) mx_pressed[c] = 1'b1;
    kb_din = {3'b101, ~mx_pressed};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // advance to the negedge following posedge number n since reset release
  task automatic goto(input int n);
    repeat (n - cyc) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b1; en = 1'b0; ev_ready = 1'b0; keys = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_ain", scan_ain, 16'hFFFF);
    check("rst_valid", ev_valid, 1'b0);
    check("rst_keys", key_state, 40'h0);
    check("rst_done", scan_done, 1'b0);
    check("rst_state", dbg_state, IDLE);

    // T1: idle matrix, row walk and scan_done cadence
    en = 1'b1; ev_ready = 1'b1; rst_n = 1'b1;
    for (int r = 0; r < 8; r++) begin
      goto(1 + 10*r);
      check($sformatf("t1_ain_first_r%0d", r), scan_ain, ROW_AIN[r]);
      goto(10 + 10*r);
      check($sformatf("t1_ain_last_r%0d", r), scan_ain, ROW_AIN[r]);
      check($sformatf("t1_done_low_r%0d", r), scan_done, 1'b0);
    end
    goto(81);
    check("t1_done_pulse", scan_done, 1'b1);
    check("t1_wrap_ain", scan_ain, 16'hF7FF);
    goto(82);
    check("t1_done_one_cycle", scan_done, 1'b0);
    check("t1_no_event", ev_valid, 1'b0);

    // T2: hold Q (code 5), then release
    keys[5] = 1'b1;
    goto(161);
    check("t2_done_scan2", scan_done, 1'b1);
    goto(241);
    check("t2_done_scan3", scan_done, 1'b1);
    goto(256);
    check("t2_pre_press_key", key_state[5], 1'b0);
    check("t2_pre_press_valid", ev_valid, 1'b0);
    goto(257);
    check("t2_press_key", key_state[5], 1'b1);
    check("t2_press_valid", ev_valid, 1'b1);
    check("t2_press_code", ev_code, 6'd5);
    check("t2_press_dir", ev_press, 1'b1);
    goto(258);
    check("t2_press_popped", ev_valid, 1'b0);
    goto(260);
    keys[5] = 1'b0;
    goto(496);
    check("t2_pre_rel_key", key_state[5], 1'b1);
    check("t2_pre_rel_valid", ev_valid, 1'b0);
    goto(497);
    check("t2_rel_key", key_state[5], 1'b0);
    check("t2_rel_valid", ev_valid, 1'b1);
    check("t2_rel_code", ev_code, 6'd5);
    check("t2_rel_dir", ev_press, 1'b0);
    goto(498);
    check("t2_rel_popped", ev_valid, 1'b0);

    // T3: code 12 bounces (2 scans pressed, 1 released, repeat) and never flips
    keys[12] = 1'b1;
    goto(600);
    keys[12] = 1'b0;
    check("t3_key_mid1", key_state[12], 1'b0);
    goto(680);
    keys[12] = 1'b1;
    goto(840);
    keys[12] = 1'b0;
    check("t3_key_mid2", key_state[12], 1'b0);
    goto(920);
    check("t3_all_keys", key_state, 40'h0);
    check("t3_no_event", ev_valid, 1'b0);

    // T4: backpressure, five presses into a four-deep queue
    ev_ready = 1'b0;
    keys[4:0] = 5'h1F;
    goto(1126);
    check("t4_pre_valid", ev_valid, 1'b0);
    goto(1127);
    check("t4_first_valid", ev_valid, 1'b1);
    check("t4_first_code", ev_code, 6'd0);
    check("t4_first_keys", key_state[4:0], 5'b00001);
    goto(1130);
    check("t4_four_keys", key_state[4:0], 5'b01111);
    goto(1140);
    check("t4_stall_keys", key_state[4:0], 5'b01111);
    check("t4_stall_ain", scan_ain, 16'hF7FF);
    check("t4_stall_state", dbg_state, EVAL);
    check("t4_stall_head", ev_code, 6'd0);
    ev_ready = 1'b1;
    goto(1141);
    check("t4_resume_keys", key_state[4:0], 5'b11111);
    check("t4_resume_ain", scan_ain, 16'hFBFF);
    check("t4_order_1", ev_code, 6'd1);
    goto(1142);
    check("t4_order_2", ev_code, 6'd2);
    goto(1143);
    check("t4_order_3", ev_code, 6'd3);
    goto(1144);
    check("t4_order_4", ev_code, 6'd4);
    check("t4_order_4_dir", ev_press, 1'b1);
    goto(1145);
    check("t4_drained", ev_valid, 1'b0);

    // T5: release all five with ev_ready low, then reset mid-stall
    goto(1150);
    ev_ready = 1'b0;
    keys[4:0] = 5'h00;
    goto(1376);
    check("t5_pre_rel_keys", key_state[4:0], 5'b11111);
    check("t5_pre_rel_valid", ev_valid, 1'b0);
    goto(1377);
    check("t5_rel0_keys", key_state[4:0], 5'b11110);
    check("t5_rel0_code", ev_code, 6'd0);
    check("t5_rel0_dir", ev_press, 1'b0);
    goto(1390);
    check("t5_stall_keys", key_state[4:0], 5'b10000);
    check("t5_stall_ain", scan_ain, 16'hF7FF);
    check("t5_stall_state", dbg_state, EVAL);
    check("t5_stall_valid", ev_valid, 1'b1);
    rst_n = 1'b0;
    keys[7] = 1'b1;
    ev_ready = 1'b1;
    #1;
    check("t5_async_ain", scan_ain, 16'hFFFF);
    check("t5_async_valid", ev_valid, 1'b0);
    check("t5_async_keys", key_state, 40'h0);
    check("t5_async_state", dbg_state, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    goto(178);
    check("t5_pre_press_keys", key_state, 40'h0);
    check("t5_pre_press_valid", ev_valid, 1'b0);
    goto(179);
    check("t5_press_keys", key_state, 40'h80);
    check("t5_press_valid", ev_valid, 1'b1);
    check("t5_press_code", ev_code, 6'd7);
    check("t5_press_dir", ev_press, 1'b1);
    goto(180);
    check("t5_press_popped", ev_valid, 1'b0);

    // T6: disable during row 2 DRIVE, then re-enable
    goto(182);
    en = 1'b0;
    goto(190);
    check("t6_row2_eval_ain", scan_ain, 16'hFDFF);
    goto(191);
    check("t6_idle_ain", scan_ain, 16'hFFFF);
    check("t6_idle_state", dbg_state, IDLE);
    goto(195);
    check("t6_idle_hold_ain", scan_ain, 16'hFFFF);
    en = 1'b1;
    goto(196);
    check("t6_restart_ain", scan_ain, 16'hF7FF);
    goto(206);
    check("t6_row1_ain", scan_ain, 16'hFBFF);
    check("t6_keys_kept", key_state, 40'h80);
    check("t6_no_event", ev_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
